// File: rtl/cla_word_sequencer.sv
// -----------------------------------------------------------------------------
// cla_word_sequencer
//
// Multi-word add/subtract sequencer built around one combinational 32-bit
// carry-lookahead adder. Operand limbs arrive least-significant first. The
// adder carry-out is registered and fed back as the next limb's carry-in.
// Registered sum limbs leave on a downstream stream.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start, sub        begin an operation (IDLE only); sub=1 selects A-B
//   in_valid/in_ready operand limb stream (A_word, B_word)
//   out_valid/out_ready result limb stream (S_word, out_last)
//   Cout_final        final carry-out, meaningful while out_last is high
//   overflow          two's-complement overflow of the full-width result,
//                     meaningful while out_last is high
//   busy              high from start acceptance until the last limb is consumed
//   done              one-cycle pulse after the last limb is consumed
//   dbg_state         current FSM state (IDLE=0, RUN=1, FLUSH=2)
//
// Handshake: on both streams a beat transfers on a rising edge where valid
// and ready are both high. A producer holds valid and its data stable until
// the transfer. in_ready is combinational and depends on out_ready, so an
// accept and a consume of the single output register can share one cycle.
// -----------------------------------------------------------------------------
module cla_word_sequencer #(
    parameter int WORDS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] A_word,
    input  logic [31:0] B_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] S_word,
    output logic        out_last,
    output logic        Cout_final,
    output logic        overflow,
    output logic        busy,
    output logic        done,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    // One spare bit so the count reaches WORDS without wrapping.
    localparam int CW = $clog2(WORDS) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WORDS - 1);

    logic [1:0]    state;
    logic          mode_r;
    logic          carry_r;
    logic [CW-1:0] cnt;

    // -------------------------------------------------------------------------
    // 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries
    // chained by group generate/propagate.
    // -------------------------------------------------------------------------
    logic [31:0] beff;
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [31:0] sum;
    logic [7:0]  gg;
    logic [7:0]  pg;
    logic        gc;
    logic        cout;

    // Subtraction is A + ~B + 1; the +1 comes from carry_r seeded with sub.
    assign beff = B_word ^ {32{mode_r}};

    always_comb begin
        g    = A_word & beff;
        p    = A_word ^ beff;
        gg   = '0;
        pg   = '0;
        c    = '0;
        gc   = carry_r;
        for (int b = 0; b < 32; b += 4) begin
            gg[b/4] = g[b+3]
                    | (p[b+3] & g[b+2])
                    | (p[b+3] & p[b+2] & g[b+1])
                    | (p[b+3] & p[b+2] & p[b+1] & g[b]);
            pg[b/4] = p[b+3] & p[b+2] & p[b+1] & p[b];
            c[b]    = gc;
            c[b+1]  = g[b] | (p[b] & gc);
            c[b+2]  = g[b+1] | (p[b+1] & g[b]) | (p[b+1] & p[b] & gc);
            c[b+3]  = g[b+2]
                    | (p[b+2] & g[b+1])
                    | (p[b+2] & p[b+1] & g[b])
                    | (p[b+2] & p[b+1] & p[b] & gc);
            gc      = gg[b/4] | (pg[b/4] & gc);
        end
        cout = gc;
        sum  = p ^ c;
    end

    // -------------------------------------------------------------------------
    // Stream control
    // -------------------------------------------------------------------------
    logic accept;
    logic consume;
    logic is_last;

    assign in_ready  = (state == ST_RUN) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign is_last   = (cnt == LAST_CNT);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            mode_r     <= 1'b0;
            carry_r    <= 1'b0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            S_word     <= '0;
            out_last   <= 1'b0;
            Cout_final <= 1'b0;
            overflow   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;

            // Single output register: a new accept overwrites it even when
            // the previous beat is consumed on the same edge.
            if (accept) begin
                S_word    <= sum;
                carry_r   <= cout;
                out_valid <= 1'b1;
                out_last  <= is_last;
                cnt       <= cnt + CW'(1);
                if (is_last) begin
                    Cout_final <= cout;
                    // Carry into the MSB is A^B^S at bit 31; XOR with the
                    // carry out of the MSB gives signed overflow.
                    overflow   <= cout ^ (A_word[31] ^ beff[31] ^ sum[31]);
                end
            end else if (consume) begin
                out_valid <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mode_r  <= sub;
                        carry_r <= sub;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept && is_last) begin
                        state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if (consume) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_word_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cla_word_sequencer
//
// Drives a WORDS=4 instance through a table of fixed vectors, hand-written
// sequences (backpressure, reset mid-op, start while busy, start in the done
// cycle) and random operations checked against a 128-bit arithmetic model.
// A WORDS=1 instance covers the single-limb signed-overflow cases.
// -----------------------------------------------------------------------------
module tb_cla_word_sequencer;

    localparam int WORDS = 4;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------------------------------------------------------- DUT (WORDS=4)
    logic        start, sub, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] A_word, B_word, S_word;
    logic        out_last, Cout_final, overflow, busy, done;
    logic [1:0]  dbg_state;

    cla_word_sequencer #(.WORDS(WORDS)) u_dut (
        .clk(clk), .rst(rst), .start(start), .sub(sub),
        .in_valid(in_valid), .in_ready(in_ready),
        .A_word(A_word), .B_word(B_word),
        .out_valid(out_valid), .out_ready(out_ready),
        .S_word(S_word), .out_last(out_last),
        .Cout_final(Cout_final), .overflow(overflow),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    // ---------------------------------------------------------------- DUT (WORDS=1)
    logic        start1, sub1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [31:0] A_word1, B_word1, S_word1;
    logic        out_last1, Cout_final1, overflow1, busy1, done1;
    logic [1:0]  dbg_state1;

    cla_word_sequencer #(.WORDS(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .sub(sub1),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .A_word(A_word1), .B_word(B_word1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .S_word(S_word1), .out_last(out_last1),
        .Cout_final(Cout_final1), .overflow(overflow1),
        .busy(busy1), .done(done1), .dbg_state(dbg_state1)
    );

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired before the expected event (cycle %0d)", name, cyc);
    endtask

    // ---------------------------------------------------------------- reference model
    // Full-width arithmetic on 128-bit values; the limb split happens afterwards.
    function automatic void ref_model(input logic [127:0] a, input logic [127:0] b,
                                      input logic sb, output logic [127:0] s,
                                      output logic cf, output logic ov);
        logic [128:0] t;
        t = '0;
        if (sb) begin
            s  = a - b;
            cf = (a >= b);
            ov = (a[127] != b[127]) && (s[127] != a[127]);
        end else begin
            t  = {1'b0, a} + {1'b0, b};
            s  = t[127:0];
            cf = t[128];
            ov = (a[127] == b[127]) && (s[127] != a[127]);
        end
    endfunction

    // ---------------------------------------------------------------- scoreboard
    // Entry = {last, cout_final, overflow, s_word}
    logic [34:0] exp_q[$];
    logic [34:0] mon_e;
    int          beat_total = 0;
    int          beat_cyc[0:1023];
    int          done_cyc   = -1;
    logic        done_busy  = 1'b1;

    task automatic push_beats(input logic [127:0] s, input logic cf, input logic ov);
        for (int i = 0; i < WORDS; i++)
            exp_q.push_back({(i == WORDS - 1), cf, ov, s[32*i +: 32]});
    endtask

    task automatic push_expect(input logic [127:0] a, input logic [127:0] b, input logic sb);
        logic [127:0] s;
        logic         cf, ov;
        ref_model(a, b, sb, s, cf, ov);
        push_beats(s, cf, ov);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (beat_total < 1024) beat_cyc[beat_total] = cyc;
            beat_total++;
            if (exp_q.size() == 0) begin
                check("extra_beat", 128'(1), 128'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("s_word", 128'(S_word), 128'(mon_e[31:0]));
                check("out_last", 128'(out_last), 128'(mon_e[34]));
                if (mon_e[34]) begin
                    check("cout_final", 128'(Cout_final), 128'(mon_e[33]));
                    check("overflow", 128'(overflow), 128'(mon_e[32]));
                end
            end
        end
        if (!rst && done) begin
            done_cyc  = cyc;
            done_busy = busy;
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // All driver tasks begin and end 1 time unit after a rising edge.
    bit rand_bp = 1'b0;

    task automatic do_start(input logic sb);
        start = 1'b1;
        sub   = sb;
        @(posedge clk); #1;
        start = 1'b0;
        sub   = 1'b0;
    endtask

    task automatic send_limb(input logic [31:0] a, input logic [31:0] b);
        bit acc = 1'b0;
        in_valid = 1'b1;
        A_word   = a;
        B_word   = b;
        for (int t = 0; t < 100; t++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid = 1'b0;
        if (!acc) bound_fail("limb_accept_timeout");
    endtask

    task automatic feed_limbs(input logic [127:0] a, input logic [127:0] b);
        for (int i = 0; i < WORDS; i++) send_limb(a[32*i +: 32], b[32*i +: 32]);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int t = 0; t < 400; t++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        if (!ok) bound_fail("idle_timeout");
    endtask

    task automatic run_w1(input logic [31:0] a, input logic [31:0] b, input logic sb,
                          input logic [31:0] s, input logic cf, input logic ov);
        bit acc = 1'b0;
        start1 = 1'b1;
        sub1   = sb;
        @(posedge clk); #1;
        start1    = 1'b0;
        sub1      = 1'b0;
        in_valid1 = 1'b1;
        A_word1   = a;
        B_word1   = b;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            acc = in_ready1;
            @(posedge clk); #1;
            if (acc) break;
        end
        in_valid1 = 1'b0;
        if (!acc) bound_fail("w1_accept_timeout");
        @(negedge clk);
        check("w1_out_valid", 128'(out_valid1), 128'(1));
        check("w1_s_word", 128'(S_word1), 128'(s));
        check("w1_out_last", 128'(out_last1), 128'(1));
        check("w1_cout_final", 128'(Cout_final1), 128'(cf));
        check("w1_overflow", 128'(overflow1), 128'(ov));
        @(posedge clk); #1;
        @(negedge clk);
        check("w1_done", 128'(done1), 128'(1));
        check("w1_busy_fall", 128'(busy1), 128'(0));
        check("w1_state_idle", 128'(dbg_state1), 128'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("w1_done_pulse", 128'(done1), 128'(0));
        @(posedge clk); #1;
    endtask

    // ---------------------------------------------------------------- vector table
    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         sb;
        logic [127:0] s;
        logic         cf;
        logic         ov;
    } vec_t;

    function automatic vec_t mk(input logic [127:0] a, input logic [127:0] b, input logic sb,
                                input logic [127:0] s, input logic cf, input logic ov);
        vec_t v;
        v.a = a; v.b = b; v.sb = sb; v.s = s; v.cf = cf; v.ov = ov;
        return v;
    endfunction

    vec_t v4[7];
    vec_t v1[4];

    // ---------------------------------------------------------------- watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- main sequence
    initial begin
        logic [127:0] ra, rb, rs;
        logic         rsb, rcf, rov;
        int           base;
        bit           seen;

        v4[0] = mk({4{32'hFFFFFFFF}}, 128'h1, 1'b0, 128'h0, 1'b1, 1'b0);
        v4[1] = mk(128'h0, 128'h1, 1'b1, {4{32'hFFFFFFFF}}, 1'b0, 1'b0);
        v4[2] = mk(128'h00000001_00000000_00000000_00000000, 128'h1, 1'b0,
                   128'h00000001_00000000_00000000_00000001, 1'b0, 1'b0);
        v4[3] = mk(128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h1, 1'b0,
                   128'h80000000_00000000_00000000_00000000, 1'b0, 1'b1);
        v4[4] = mk(128'h80000000_00000000_00000000_00000000, 128'h1, 1'b1,
                   128'h7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 1'b1, 1'b1);
        v4[5] = mk(128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
                   128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b1, 128'h0, 1'b1, 1'b0);
        v4[6] = mk(128'h00000000_FFFFFFFF_00000000_FFFFFFFF,
                   128'h00000000_00000001_00000000_00000001, 1'b0,
                   128'h00000001_00000000_00000001_00000000, 1'b0, 1'b0);

        v1[0] = mk(128'h7FFFFFFF, 128'h1, 1'b0, 128'h80000000, 1'b0, 1'b1);
        v1[1] = mk(128'h80000000, 128'h1, 1'b1, 128'h7FFFFFFF, 1'b1, 1'b1);
        v1[2] = mk(128'hFFFFFFFF, 128'h1, 1'b0, 128'h0, 1'b1, 1'b0);
        v1[3] = mk(128'h5, 128'h7, 1'b1, 128'hFFFFFFFE, 1'b0, 1'b0);

        rst = 1'b1;
        start = 1'b0; sub = 1'b0; in_valid = 1'b0; A_word = '0; B_word = '0;
        out_ready = 1'b1;
        start1 = 1'b0; sub1 = 1'b0; in_valid1 = 1'b0; A_word1 = '0; B_word1 = '0;
        out_ready1 = 1'b1;

        // ---- reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_s_word", 128'(S_word), 128'(0));
        check("rst_flags", 128'({out_last, Cout_final, overflow, busy, done}), 128'(0));
        check("rst_state", 128'(dbg_state), 128'(0));
        check("rst_w1_outputs", 128'({out_valid1, in_ready1, S_word1, out_last1, Cout_final1,
                                      overflow1, busy1, done1, dbg_state1}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- table vectors, out_ready held high: 1 limb/cycle, done one cycle after last
        for (int i = 0; i < 7; i++) begin
            base = beat_total;
            push_beats(v4[i].s, v4[i].cf, v4[i].ov);
            do_start(v4[i].sb);
            feed_limbs(v4[i].a, v4[i].b);
            wait_idle();
            check("tbl_beat_count", 128'(beat_total - base), 128'(WORDS));
            check("tbl_back_to_back", 128'(beat_cyc[base + WORDS - 1] - beat_cyc[base]),
                  128'(WORDS - 1));
            check("tbl_done_latency", 128'(done_cyc - beat_cyc[base + WORDS - 1]), 128'(1));
            check("tbl_busy_with_done", 128'(done_busy), 128'(0));
        end

        // ---- single-limb signed overflow cases
        for (int i = 0; i < 4; i++)
            run_w1(v1[i].a[31:0], v1[i].b[31:0], v1[i].sb, v1[i].s[31:0], v1[i].cf, v1[i].ov);

        // ---- backpressure: out_ready low for 3 cycles after the 2nd limb
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        ref_model(ra, rb, 1'b0, rs, rcf, rov);
        push_beats(rs, rcf, rov);
        base = beat_total;
        do_start(1'b0);
        send_limb(ra[31:0], rb[31:0]);
        send_limb(ra[63:32], rb[63:32]);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        A_word    = ra[95:64];
        B_word    = rb[95:64];
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_in_ready", 128'(in_ready), 128'(0));
            check("stall_out_valid", 128'(out_valid), 128'(1));
            check("stall_s_stable", 128'(S_word), 128'(rs[63:32]));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send_limb(ra[95:64], rb[95:64]);
        send_limb(ra[127:96], rb[127:96]);
        wait_idle();
        check("stall_beat_count", 128'(beat_total - base), 128'(WORDS));

        // ---- reset mid-operation (carry_r is 1 when reset hits)
        push_expect({4{32'hFFFFFFFF}}, {4{32'h00000001}}, 1'b0);
        do_start(1'b0);
        send_limb(32'hFFFFFFFF, 32'h00000001);
        send_limb(32'hFFFFFFFF, 32'h00000001);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 128'(out_valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_s_word", 128'(S_word), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(0));
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        push_expect(128'h00000001_00000000_00000000_00000000, 128'h1, 1'b0);
        do_start(1'b0);
        feed_limbs(128'h00000001_00000000_00000000_00000000, 128'h1);
        wait_idle();
        check("midrst_recover_drained", 128'(exp_q.size()), 128'(0));

        // ---- start coinciding with in_valid, start while busy, start in done cycle
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        push_expect(ra, rb, 1'b0);
        start    = 1'b1;
        sub      = 1'b0;
        in_valid = 1'b1;
        A_word   = ra[31:0];
        B_word   = rb[31:0];
        @(negedge clk);
        check("idle_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        start = 1'b0;
        send_limb(ra[31:0], rb[31:0]);
        start = 1'b1;
        sub   = 1'b1;
        send_limb(ra[63:32], rb[63:32]);
        start = 1'b0;
        sub   = 1'b0;
        check("busy_start_state", 128'(dbg_state), 128'(1));
        send_limb(ra[95:64], rb[95:64]);
        send_limb(ra[127:96], rb[127:96]);
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!seen) bound_fail("done_wait_timeout");
        ra = {$urandom, $urandom, $urandom, $urandom};
        rb = {$urandom, $urandom, $urandom, $urandom};
        push_expect(ra, rb, 1'b1);
        start = 1'b1;
        sub   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        sub   = 1'b0;
        check("done_cycle_start_busy", 128'(busy), 128'(1));
        check("done_cycle_start_state", 128'(dbg_state), 128'(1));
        feed_limbs(ra, rb);
        wait_idle();

        // ---- random operations, random backpressure on most of them
        for (int r = 0; r < 24; r++) begin
            ra  = {$urandom, $urandom, $urandom, $urandom};
            rb  = {$urandom, $urandom, $urandom, $urandom};
            if (r % 6 == 0) rb = ra;
            rsb = 1'($urandom_range(0, 1));
            rand_bp = (r >= 6);
            base = beat_total;
            push_expect(ra, rb, rsb);
            do_start(rsb);
            feed_limbs(ra, rb);
            wait_idle();
            check("rand_beat_count", 128'(beat_total - base), 128'(WORDS));
        end
        rand_bp   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'(0));
        check("final_idle", 128'({busy, out_valid, dbg_state}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
